id_ex_stage: RTL

Decode-to-execute pipeline boundary of the five-stage RISC-V core. Registers the decoded instruction (control bundle, operands, PC, immediate, register indices) into the execute stage. Detects load-use hazards and inserts bubbles. Generates the stall and flush signals for fetch/decode and the operand-forwarding selects the execute stage uses to pick ALU sources.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/hazard_unit.sv | 63 ++++++
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: decoded control bundle, result-source and
// forwarding-select encodings used across the five-stage core.
package pipeline_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use stall detection, branch flush and
// ALU operand forwarding selects for the execute stage.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ValidD,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic                      ValidE,
    input  logic [1:0]                ResultSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      PCSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE
);

    logic lw_stall;
    logic m_fwd_ok;
    logic w_fwd_ok;

    assign lw_stall = ValidE && (ResultSrcE == RESULT_SRC_MEM) && (RdE != '0)
                   && ValidD && ((Rs1D == RdE) || (Rs2D == RdE));

    // A taken branch discards the dependent instruction anyway, so it suppresses the stall.
    assign StallF = lw_stall && !PCSrcE;
    assign StallD = lw_stall && !PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = lw_stall || PCSrcE;

    assign m_fwd_ok = RegWriteM && (RdM != '0);
    assign w_fwd_ok = RegWriteW && (RdW != '0);

    always_comb begin
        ForwardAE = FWD_RF;
        if (m_fwd_ok && (RdM == Rs1E)) begin
            ForwardAE = FWD_MEM;
        end else if (w_fwd_ok && (RdW == Rs1E)) begin
            ForwardAE = FWD_WB;
        end
    end

    always_comb begin
        ForwardBE = FWD_RF;
        if (m_fwd_ok && (RdM == Rs2E)) begin
            ForwardBE = FWD_MEM;
        end else if (w_fwd_ok && (RdW == Rs2E)) begin
            ForwardBE = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion;
// hazard and forwarding decisions come from hazard_unit.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ValidD,
    input  ctrl_t                     CtrlD,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic                      PCSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    output logic                      ValidE,
    output ctrl_t                     CtrlE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      FlushD,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE
);

    logic flush_e;

    logic                      valid_q,  valid_d;
    ctrl_t                     ctrl_q,   ctrl_d;
    logic [DATA_WIDTH-1:0]     rd1_q,    rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q,    rd2_d;
    logic [DATA_WIDTH-1:0]     pc_q,     pc_d;
    logic [DATA_WIDTH-1:0]     imm_q,    imm_d;
    logic [DATA_WIDTH-1:0]     pc4_q,    pc4_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,    rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,    rs2_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,     rd_d;

    hazard_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard (
        .ValidD    (ValidD),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .ValidE    (valid_q),
        .ResultSrcE(ctrl_q.ResultSrc),
        .Rs1E      (rs1_q),
        .Rs2E      (rs2_q),
        .RdE       (rd_q),
        .PCSrcE    (PCSrcE),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (flush_e),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    // A bubble is fully zeroed so its zero indices can never match a forwarding source.
    always_comb begin
        valid_d = ValidD;
        ctrl_d  = CtrlD;
        rd1_d   = RD1D;
        rd2_d   = RD2D;
        pc_d    = PCD;
        imm_d   = ImmExtD;
        pc4_d   = PCPlus4D;
        rs1_d   = Rs1D;
        rs2_d   = Rs2D;
        rd_d    = RdD;
        if (flush_e) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            pc_d    = '0;
            imm_d   = '0;
            pc4_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    assign ValidE   = valid_q;
    assign CtrlE    = ctrl_q;
    assign RD1E     = rd1_q;
    assign RD2E     = rd2_q;
    assign PCE      = pc_q;
    assign ImmExtE  = imm_q;
    assign PCPlus4E = pc4_q;
    assign Rs1E     = rs1_q;
    assign Rs2E     = rs2_q;
    assign RdE      = rd_q;

endmodule
